prog_fsm: RTL and testbench

PROG_FSM -- requirements
Module: prog_fsm

---
 rtl/prog_fsm_pkg.sv | 29 ++
 rtl/prog_fsm_cfg_sr.sv | 102 ++++++++++
 rtl/prog_fsm.sv | 107 ++++++++++
 tb/tb_prog_fsm.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_fsm_pkg.sv
// prog_fsm_pkg: shared defaults, entry layout and sizing helper for prog_fsm.
// The optional readback port is enabled with PROG_FSM_READBACK_EN.
package prog_fsm_pkg;

  localparam int DEF_N_STATES = 5;
  localparam int DEF_IN_W     = 5;

  // Each table entry is {sel, target}: target in the low bits, sel above it,
  // so sel is the first field shifted in when loading MSB first.
  localparam int ENTRY_TGT_LSB = 0;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_READ = 2'd2
  } cfg_mode_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int entry_sel_lsb(input int state_w);
    return ENTRY_TGT_LSB + state_w;
  endfunction

endpackage

// File: rtl/prog_fsm_cfg_sr.sv
// prog_fsm_cfg_sr: serial-in/parallel-out transition table register with load
// tracking; serial readback is built only when PROG_FSM_READBACK_EN is defined.
module prog_fsm_cfg_sr
  import prog_fsm_pkg::*;
#(
  parameter int TOTAL_BITS = 30
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  cfg_in,
  input  logic                  cfg_en,
  input  logic                  cfg_clr,
  input  logic                  rd_start,
  output logic [TOTAL_BITS-1:0] table_q,
  output logic                  load_last,
  output logic                  cfg_done,
  output logic                  rd_busy,
  output logic                  cfg_out
);

  localparam int CNT_W = clog2_min1(TOTAL_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL_BITS - 1);

  cfg_mode_e             mode_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [TOTAL_BITS-1:0] sr_reg;

  assign table_q   = sr_reg;
  assign cfg_done  = (mode_reg != MODE_LOAD);
  assign load_last = (mode_reg == MODE_LOAD) && cfg_en && !cfg_clr && (cnt_reg == CNT_LAST);

`ifdef PROG_FSM_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
  // Readback shifts a copy so the live table seen by the FSM never moves.
  logic [TOTAL_BITS-1:0] rd_sr_reg;
  logic                  cfg_out_reg;

  assign rd_busy = (mode_reg == MODE_READ);
  assign cfg_out = cfg_out_reg;
`else
  logic unused_rd_start;

  assign unused_rd_start = rd_start;
  assign rd_busy         = 1'b0;
  assign cfg_out         = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      mode_reg    <= MODE_LOAD;
      cnt_reg     <= '0;
      sr_reg      <= '0;
`ifdef PROG_FSM_READBACK_EN
      rd_sr_reg   <= '0;
      cfg_out_reg <= 1'b0;
`endif
    end else if (cfg_clr) begin
      mode_reg    <= MODE_LOAD;
      cnt_reg     <= '0;
`ifdef PROG_FSM_READBACK_EN
      cfg_out_reg <= 1'b0;
`endif
    end else begin
      case (mode_reg)
        MODE_LOAD: begin
          if (cfg_en) begin
            sr_reg <= {sr_reg[TOTAL_BITS-2:0], cfg_in};
            if (cnt_reg == CNT_LAST) begin
              mode_reg <= MODE_RUN;
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
`ifdef PROG_FSM_READBACK_EN
        MODE_RUN: begin
          if (rd_start) begin
            mode_reg    <= MODE_READ;
            cnt_reg     <= CNT_W'(1);
            cfg_out_reg <= sr_reg[TOTAL_BITS-1];
            rd_sr_reg   <= {sr_reg[TOTAL_BITS-2:0], 1'b0};
          end
        end
        MODE_READ: begin
          if (cnt_reg == CNT_FULL) begin
            mode_reg    <= MODE_RUN;
            cnt_reg     <= '0;
            cfg_out_reg <= 1'b0;
          end else begin
            cfg_out_reg <= rd_sr_reg[TOTAL_BITS-1];
            rd_sr_reg   <= {rd_sr_reg[TOTAL_BITS-2:0], 1'b0};
            cnt_reg     <= cnt_reg + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/prog_fsm.sv
// prog_fsm: N-state FSM whose {sel, target} transition table is loaded serially.
// Define PROG_FSM_READBACK_EN to build the serial table readback port.
module prog_fsm
  import prog_fsm_pkg::*;
#(
  parameter  int N_STATES = DEF_N_STATES,
  parameter  int IN_W     = DEF_IN_W,
  localparam int STATE_W  = clog2_min1(N_STATES)
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [IN_W-1:0]     in,
  input  logic                cfg_in,
  input  logic                cfg_en,
  input  logic                cfg_clr,
  input  logic                rd_start,
  output logic [N_STATES-1:0] state_oh,
  output logic [STATE_W-1:0]  state_idx,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                cfg_out,
  output logic                rd_busy
);

  localparam int SEL_W      = clog2_min1(IN_W);
  localparam int ENTRY_W    = SEL_W + STATE_W;
  localparam int TOTAL_BITS = N_STATES * ENTRY_W;
  localparam int SEL_LSB    = entry_sel_lsb(STATE_W);
  localparam logic [STATE_W:0] N_STATES_C = (STATE_W + 1)'(N_STATES);
  localparam logic [SEL_W:0]   IN_W_C     = (SEL_W + 1)'(IN_W);

  logic [TOTAL_BITS-1:0] table_q;
  logic [TOTAL_BITS-1:0] table_shift;
  logic                  load_last;
  logic [SEL_W-1:0]      sel_arr [N_STATES];
  logic [STATE_W-1:0]    tgt_arr [N_STATES];
  logic [N_STATES-1:0]   bad_vec;
  logic [STATE_W-1:0]    state_reg;
  logic                  cfg_err_reg;
  logic [(1 << SEL_W)-1:0] in_ext;
  logic [SEL_W-1:0]      cur_sel;
  logic [STATE_W-1:0]    cur_tgt;
  logic                  cond;
  logic [STATE_W-1:0]    state_next;

  prog_fsm_cfg_sr #(
    .TOTAL_BITS(TOTAL_BITS)
  ) u_cfg_sr (
    .clk_in   (clk_in),
    .reset    (reset),
    .cfg_in   (cfg_in),
    .cfg_en   (cfg_en),
    .cfg_clr  (cfg_clr),
    .rd_start (rd_start),
    .table_q  (table_q),
    .load_last(load_last),
    .cfg_done (cfg_done),
    .rd_busy  (rd_busy),
    .cfg_out  (cfg_out)
  );

  // Range check looks at the table as it will be after this edge's shift,
  // so cfg_err can rise on the same edge as cfg_done.
  assign table_shift = {table_q[TOTAL_BITS-2:0], cfg_in};

  for (genvar gi = 0; gi < N_STATES; gi++) begin : g_entry
    localparam int BASE = TOTAL_BITS - (gi + 1) * ENTRY_W;
    assign sel_arr[gi] = table_q[BASE + SEL_LSB +: SEL_W];
    assign tgt_arr[gi] = table_q[BASE + ENTRY_TGT_LSB +: STATE_W];
    assign bad_vec[gi] =
      ({1'b0, table_shift[BASE + ENTRY_TGT_LSB +: STATE_W]} >= N_STATES_C) ||
      ({1'b0, table_shift[BASE + SEL_LSB +: SEL_W]} >= IN_W_C);
  end

  // Zero-extending the condition bus makes an out-of-range sel read as false.
  always_comb begin
    in_ext            = '0;
    in_ext[IN_W-1:0]  = in;
    cur_sel           = sel_arr[state_reg];
    cur_tgt           = tgt_arr[state_reg];
    cond              = in_ext[cur_sel];
    state_next        = ({1'b0, cur_tgt} < N_STATES_C) ? cur_tgt : '0;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg   <= '0;
      cfg_err_reg <= 1'b0;
    end else if (cfg_clr) begin
      state_reg   <= '0;
      cfg_err_reg <= 1'b0;
    end else if (!cfg_done) begin
      state_reg <= '0;
      if (load_last && (|bad_vec)) cfg_err_reg <= 1'b1;
    end else if (cond) begin
      state_reg <= state_next;
    end
  end

  for (genvar gi = 0; gi < N_STATES; gi++) begin : g_oh
    assign state_oh[gi] = (state_reg == STATE_W'(gi));
  end

  assign state_idx = state_reg;
  assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_prog_fsm.sv
// tb_prog_fsm: vector table, corner-case sequences and randomized runs of
// prog_fsm checked against a table-lookup reference model.
module tb_prog_fsm;

  localparam int NS = 5;
  localparam int IW = 5;
  localparam int EW = 6;
  localparam int TB = 30;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [IW-1:0] in_v;
  logic          cfg_in;
  logic          cfg_en;
  logic          cfg_clr;
  logic          rd_start;
  logic [NS-1:0] state_oh;
  logic [2:0]    state_idx;
  logic          cfg_done;
  logic          cfg_err;
  logic          cfg_out;
  logic          rd_busy;

  prog_fsm #(.N_STATES(NS), .IN_W(IW)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .in       (in_v),
    .cfg_in   (cfg_in),
    .cfg_en   (cfg_en),
    .cfg_clr  (cfg_clr),
    .rd_start (rd_start),
    .state_oh (state_oh),
    .state_idx(state_idx),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .cfg_out  (cfg_out),
    .rd_busy  (rd_busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [IW-1:0] in_v;
    int            exp_idx;
  } vec_t;

  vec_t vecs[12];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   sel_m[NS];
  int   tgt_m[NS];
  int   st_m;
  bit   err_m;
  bit   stream_b[TB];

  task automatic check(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_state(input string name, input int exp_idx);
    check({name, "_idx"}, int'(state_idx), exp_idx);
    check({name, "_oh"}, int'(state_oh), 1 << exp_idx);
  endtask

  function automatic int model_next(input int s, input logic [IW-1:0] iv);
    if (sel_m[s] < IW && iv[sel_m[s]]) return (tgt_m[s] < NS) ? tgt_m[s] : 0;
    return s;
  endfunction

  // Entry 0 first, each entry MSB first with sel ahead of target.
  task automatic build_stream();
    int val;
    err_m = 1'b0;
    for (int k = 0; k < TB; k++) begin
      val = ((sel_m[k / EW] & 7) << 3) | (tgt_m[k / EW] & 7);
      stream_b[k] = bit'((val >> (EW - 1 - (k % EW))) & 1);
    end
    for (int i = 0; i < NS; i++)
      if (sel_m[i] >= IW || tgt_m[i] >= NS) err_m = 1'b1;
  endtask

  task automatic drive_bits(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      cfg_en = 1'b1;
      cfg_in = stream_b[k];
      step();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic load_full(input string name);
    build_stream();
    drive_bits(0, TB - 1);
    check({name, "_done_early"}, int'(cfg_done), 0);
    drive_bits(TB - 1, TB);
    check({name, "_done"}, int'(cfg_done), 1);
    check({name, "_err"}, int'(cfg_err), int'(err_m));
    check_state({name, "_st"}, 0);
    st_m = 0;
  endtask

  task automatic clear_table();
    cfg_clr = 1'b1;
    step();
    cfg_clr = 1'b0;
    check("clr_done", int'(cfg_done), 0);
  endtask

  initial begin
    reset = 1'b1; in_v = '0; cfg_in = 1'b0; cfg_en = 1'b0;
    cfg_clr = 1'b0; rd_start = 1'b0;

    vecs[0]  = '{5'b00001, 1};
    vecs[1]  = '{5'b00001, 1};
    vecs[2]  = '{5'b11101, 1};
    vecs[3]  = '{5'b00010, 2};
    vecs[4]  = '{5'b11011, 2};
    vecs[5]  = '{5'b00100, 3};
    vecs[6]  = '{5'b10111, 3};
    vecs[7]  = '{5'b11111, 4};
    vecs[8]  = '{5'b01111, 4};
    vecs[9]  = '{5'b11111, 0};
    vecs[10] = '{5'b11110, 0};
    vecs[11] = '{5'b11111, 1};

    #12;
    check_state("rst", 0);
    check("rst_done", int'(cfg_done), 0);
    check("rst_err", int'(cfg_err), 0);
    check("rst_busy", int'(rd_busy), 0);
    check("rst_cfg_out", int'(cfg_out), 0);
    @(negedge clk_in);
    reset = 1'b0;

    // Ring table: entry i = {sel=i, target=(i+1)%5}
    for (int i = 0; i < NS; i++) begin
      sel_m[i] = i;
      tgt_m[i] = (i + 1) % NS;
    end
    load_full("ring");

    for (int v = 0; v < 12; v++) begin
      in_v = vecs[v].in_v;
      step();
      check_state($sformatf("vec%0d", v), vecs[v].exp_idx);
    end
    st_m = vecs[11].exp_idx;
    in_v = '0;

`ifdef PROG_FSM_READBACK_EN
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int k = 0; k < TB; k++) begin
      check($sformatf("rb_busy%0d", k), int'(rd_busy), 1);
      check($sformatf("rb_bit%0d", k), int'(cfg_out), int'(stream_b[k]));
      rd_start = (k == 10);
      step();
    end
    rd_start = 1'b0;
    check("rb_busy_end", int'(rd_busy), 0);
    check("rb_out_end", int'(cfg_out), 0);
    check_state("rb_hold", st_m);
`else
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("norb_busy", int'(rd_busy), 0);
      check("norb_out", int'(cfg_out), 0);
      step();
    end
`endif

    in_v = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      step();
      st_m = model_next(st_m, in_v);
      check_state($sformatf("post_rb%0d", k), st_m);
    end

    // Entry 2 target out of range
    clear_table();
    check_state("clr_st", 0);
    tgt_m[2] = 7;
    load_full("bad");
    in_v = 5'b11111;
    step();
    check_state("bad_s1", 1);
    step();
    check_state("bad_s2", 2);
    in_v = 5'b00100;
    step();
    check_state("bad_wrap", 0);
    in_v = 5'b00001;
    step();
    check_state("bad_s1b", 1);

    // cfg_clr outranks rd_start in the same cycle
    cfg_clr = 1'b1;
    rd_start = 1'b1;
    step();
    cfg_clr = 1'b0;
    rd_start = 1'b0;
    check("clrrd_done", int'(cfg_done), 0);
    check("clrrd_busy", int'(rd_busy), 0);
    check("clrrd_err", int'(cfg_err), 0);
    check_state("clrrd_st", 0);
    step();
    check("clrrd_busy2", int'(rd_busy), 0);

    // Partial load aborted by reset needs a full reload
    tgt_m[2] = 3;
    build_stream();
    drive_bits(0, 15);
    #2 reset = 1'b1;
    #2;
    check("prst_done", int'(cfg_done), 0);
    check_state("prst_st", 0);
    @(negedge clk_in);
    reset = 1'b0;
    drive_bits(0, 15);
    check("reload15_done", int'(cfg_done), 0);
    drive_bits(15, TB);
    check("reload30_done", int'(cfg_done), 1);
    check("reload30_err", int'(cfg_err), 0);
    st_m = 0;

    // Randomized tables and inputs, with stray cfg_en that must be ignored
    for (int r = 0; r < 6; r++) begin
      clear_table();
      for (int i = 0; i < NS; i++) begin
        sel_m[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        tgt_m[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      end
      load_full($sformatf("rnd%0d", r));
      for (int c = 0; c < 50; c++) begin
        in_v = IW'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          cfg_en = 1'b1;
          cfg_in = 1'($urandom);
        end
        step();
        cfg_en = 1'b0;
        st_m = model_next(st_m, in_v);
        check_state($sformatf("rnd%0d_c%0d", r, c), st_m);
      end
      check($sformatf("rnd%0d_done_kept", r), int'(cfg_done), 1);
      check($sformatf("rnd%0d_err_kept", r), int'(cfg_err), int'(err_m));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
